// File: rtl/fsk_symbol_scheduler_if.sv
// fsk_symbol_scheduler_if: frame input, PLL lock/reset handshake and TX status bundle
interface fsk_symbol_scheduler_if;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        pll0_locked;
  logic        pll1_locked;
  logic        pll0_reset;
  logic        pll1_reset;
  logic        freq_select;
  logic        wave_enable;
  logic        busy;
  logic        frame_done;
  logic        fault;
  modport master (
    output frame_data, frame_valid, pll0_locked, pll1_locked,
    input  pll0_reset, pll1_reset, freq_select, wave_enable, busy, frame_done, fault
  );
  modport slave (
    input  frame_data, frame_valid, pll0_locked, pll1_locked,
    output pll0_reset, pll1_reset, freq_select, wave_enable, busy, frame_done, fault
  );
endinterface

// File: rtl/fsk_symbol_scheduler.sv
// fsk_symbol_scheduler: arms two PLLs, then keys 16-bit UART words LSB first as FSK symbols; FSK_PREAMBLE_EN prepends 1010_1010
module fsk_symbol_scheduler #(
  parameter int SYMBOL_CYCLES = 12000,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input logic                   clk,
  input logic                   reset_b,
  fsk_symbol_scheduler_if.slave bus
);
`ifdef FSK_PREAMBLE_EN
  localparam int PRE = 8;
`else
  localparam int PRE = 0;
`endif
  localparam logic [4:0]  LAST    = 5'(PRE + 15);
  localparam logic [15:0] SC_LAST = 16'(SYMBOL_CYCLES - 1);
  localparam logic [15:0] LT_LAST = 16'(LOCK_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ARM, TX, FAULT} state_t;
  state_t      state, nxt;
  logic        fv_q, pend_v, pend_v_n, fault_n, done_n, bit_n;
  logic [15:0] sh, sh_n, pend, pend_n, cnt, cnt_n;
  logic [4:0]  idx, idx_n;
  logic [3:0]  bi;
  logic        rise, zero_rise, word_rise, locks, sym_end;
  assign rise      = bus.frame_valid & ~fv_q;
  assign zero_rise = rise & (bus.frame_data == 16'd0);
  assign word_rise = rise & (bus.frame_data != 16'd0);
  assign locks     = bus.pll0_locked & bus.pll1_locked;
  assign sym_end   = cnt == SC_LAST;
  // next state, buffers, counters and the symbol bit the next cycle will carry
  always_comb begin
    nxt      = state;
    sh_n     = sh;
    pend_n   = pend;
    pend_v_n = pend_v;
    cnt_n    = (state == ARM || state == TX) ? cnt + 16'd1 : 16'd0;
    idx_n    = idx;
    fault_n  = bus.fault;
    done_n   = 1'b0;
    bi       = 4'd0;
    bit_n    = 1'b0;
    case (state)
      IDLE, FAULT: if (word_rise) begin
        nxt     = ARM;
        sh_n    = bus.frame_data;
        fault_n = 1'b0;
      end
      ARM: begin
        if (word_rise) begin
          pend_n   = bus.frame_data;
          pend_v_n = 1'b1;
        end
        if (zero_rise) nxt = IDLE;
        else if (locks) nxt = TX;
        else if (cnt == LT_LAST) begin
          nxt     = FAULT;
          fault_n = 1'b1;
        end
      end
      TX: begin
        if (word_rise) begin
          pend_n   = bus.frame_data;
          pend_v_n = 1'b1;
        end
        if (zero_rise) nxt = IDLE;
        else if (!locks) begin
          nxt     = FAULT;
          fault_n = 1'b1;
        end else if (sym_end) begin
          cnt_n = 16'd0;
          idx_n = idx + 5'd1;
          if (idx == LAST) begin
            idx_n = 5'd0;
            if (word_rise || pend_v) begin
              sh_n     = word_rise ? bus.frame_data : pend;
              pend_v_n = 1'b0;
            end else begin
              nxt    = IDLE;
              done_n = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
    if (nxt != state) begin
      cnt_n = 16'd0;
      idx_n = 5'd0;
    end
    if (nxt == IDLE || nxt == FAULT) pend_v_n = 1'b0;
`ifdef FSK_PREAMBLE_EN
    bi    = idx_n[3:0] - 4'd8;
    bit_n = (nxt == TX) && ((idx_n < 5'd8) ? ~idx_n[0] : sh_n[bi]);
`else
    bi    = idx_n[3:0];
    bit_n = (nxt == TX) && sh_n[bi];
`endif
  end
  // state, buffers and registered outputs; reset drops the antenna drive immediately
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state           <= IDLE;
      fv_q            <= 1'b0;
      sh              <= 16'd0;
      pend            <= 16'd0;
      pend_v          <= 1'b0;
      cnt             <= 16'd0;
      idx             <= 5'd0;
      bus.pll0_reset  <= 1'b1;
      bus.pll1_reset  <= 1'b1;
      bus.freq_select <= 1'b0;
      bus.wave_enable <= 1'b0;
      bus.busy        <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.fault       <= 1'b0;
    end else begin
      state           <= nxt;
      fv_q            <= bus.frame_valid;
      sh              <= sh_n;
      pend            <= pend_n;
      pend_v          <= pend_v_n;
      cnt             <= cnt_n;
      idx             <= idx_n;
      bus.pll0_reset  <= nxt == IDLE || nxt == FAULT;
      bus.pll1_reset  <= nxt == IDLE || nxt == FAULT;
      bus.freq_select <= bit_n;
      bus.wave_enable <= nxt == TX;
      bus.busy        <= nxt == ARM || nxt == TX;
      bus.frame_done  <= done_n;
      bus.fault       <= fault_n;
    end
  end
endmodule

// File: tb/tb_fsk_symbol_scheduler.sv
// tb_fsk_symbol_scheduler: directed and random stimulus checked every cycle against a time-based frame model
module tb_fsk_symbol_scheduler;
  localparam int SC = 4;
  localparam int LT = 16;
`ifdef FSK_PREAMBLE_EN
  localparam int NPRE = 8;
  localparam int FRAME_CYC = 96;
`else
  localparam int NPRE = 0;
  localparam int FRAME_CYC = 64;
`endif
  localparam int NSYM = NPRE + 16;
  localparam int M_IDLE = 0, M_ARM = 1, M_TX = 2, M_FAULT = 3;
  logic clk = 1'b0;
  logic reset_b = 1'b0;
  int checks = 0, failures = 0;
  fsk_symbol_scheduler_if bus();
  fsk_symbol_scheduler #(.SYMBOL_CYCLES(SC), .LOCK_TIMEOUT(LT)) dut (.clk(clk), .reset_b(reset_b), .bus(bus));
  always #5 clk = ~clk;
  // model: mode, time spent in it, word on air and a one-deep pending queue
  int m_mode = M_IDLE, m_t = 0;
  logic [15:0] m_word = '0;
  logic [15:0] m_pq[$];
  logic m_fvp = 1'b0, m_fd = 1'b0, m_fault = 1'b0;
  function automatic logic sym_bit(int s, logic [15:0] w);
    return (s < NPRE) ? ((s % 2) == 0) : w[s - NPRE];
  endfunction
  always @(posedge clk or negedge reset_b) begin
    logic rise, locks;
    logic [15:0] d;
    if (!reset_b) begin
      m_mode = M_IDLE; m_t = 0; m_pq.delete(); m_fvp = 0; m_fd = 0; m_fault = 0;
    end else begin
      rise = bus.frame_valid && !m_fvp;
      m_fvp = bus.frame_valid;
      d = bus.frame_data;
      locks = bus.pll0_locked && bus.pll1_locked;
      m_fd = 0;
      if (m_mode == M_IDLE || m_mode == M_FAULT) begin
        if (rise && d != 0) begin m_word = d; m_fault = 0; m_mode = M_ARM; m_t = 0; end
      end else if (rise && d == 0) begin
        m_pq.delete(); m_mode = M_IDLE;
      end else if (m_mode == M_ARM) begin
        if (rise) begin m_pq.delete(); m_pq.push_back(d); end
        m_t++;
        if (locks) begin m_mode = M_TX; m_t = 0; end
        else if (m_t == LT) begin m_mode = M_FAULT; m_fault = 1; m_pq.delete(); end
      end else if (!locks) begin
        m_pq.delete(); m_mode = M_FAULT; m_fault = 1;
      end else begin
        m_t++;
        if (m_t == NSYM * SC) begin
          m_t = 0;
          if (rise) begin m_word = d; m_pq.delete(); end
          else if (m_pq.size() > 0) m_word = m_pq.pop_front();
          else begin m_mode = M_IDLE; m_fd = 1; end
        end else if (rise) begin m_pq.delete(); m_pq.push_back(d); end
      end
    end
  end
  int wave_cnt = 0, busy_cnt = 0, fd_cnt = 0, run = 0, last_run = 0;
  logic fq[$];
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // one clock step: compare all outputs against the model, then update monitors
  task automatic tick();
    logic [6:0] act, exp;
    logic idle;
    @(negedge clk);
    idle = (m_mode == M_IDLE || m_mode == M_FAULT);
    exp = {idle, idle, m_mode == M_TX && sym_bit(m_t / SC, m_word), m_mode == M_TX,
           m_mode == M_ARM || m_mode == M_TX, m_fd, m_fault};
    act = {bus.pll0_reset, bus.pll1_reset, bus.freq_select, bus.wave_enable, bus.busy, bus.frame_done, bus.fault};
    check("model", 32'(act), 32'(exp));
    if (bus.wave_enable) begin wave_cnt++; run++; fq.push_back(bus.freq_select); end
    else if (run > 0) begin last_run = run; run = 0; end
    if (bus.busy) busy_cnt++;
    if (bus.frame_done) fd_cnt++;
  endtask
  task automatic ticks(int n);
    repeat (n) tick();
  endtask
  task automatic send(logic [15:0] w);
    bus.frame_valid = 0;
    tick();
    bus.frame_data = w;
    bus.frame_valid = 1;
    tick();
  endtask
  task automatic wait_idle(int lim);
    int n = 0;
    while (bus.busy && n < lim) begin tick(); n++; end
    check("idle_bound", 32'(bus.busy), 0);
  endtask
  task automatic wait_wave(int lim);
    int n = 0;
    while (!bus.wave_enable && n < lim) begin tick(); n++; end
    check("wave_bound", 32'(bus.wave_enable), 1);
  endtask
  initial begin
    int w0, b0, f0, lk0, lk1;
    logic [15:0] dw;
    logic [7:0] pw;
    logic flat;
    bus.frame_data = 0; bus.frame_valid = 0; bus.pll0_locked = 1; bus.pll1_locked = 1;
    ticks(3);
    check("reset_outputs", 32'({bus.pll0_reset, bus.pll1_reset, bus.freq_select, bus.wave_enable,
                                bus.busy, bus.frame_done, bus.fault}), 32'b1100000);
    reset_b = 1;
    ticks(2);
    send(16'h0000);
    ticks(3);
    check("zero_ignored", 32'(bus.busy), 0);
    fq.delete(); w0 = wave_cnt; f0 = fd_cnt;
    send(16'h0005);
    wait_idle(200);
    check("single_wave", 32'(wave_cnt - w0), 32'(FRAME_CYC));
    check("single_done", 32'(fd_cnt - f0), 1);
    check("single_len", 32'(fq.size()), 32'(FRAME_CYC));
    if (fq.size() == FRAME_CYC) begin
      dw = 0; pw = 0; flat = 1;
      for (int s = 0; s < NSYM; s++) begin
        for (int k = 1; k < SC; k++) if (fq[s * SC + k] != fq[s * SC]) flat = 0;
        if (s < NPRE) pw[s] = fq[s * SC]; else dw[s - NPRE] = fq[s * SC];
      end
      check("single_flat", 32'(flat), 1);
      check("single_data", 32'(dw), 32'h0005);
      if (NPRE > 0) check("preamble", 32'(pw), 32'h55);
    end
    bus.pll1_locked = 0; b0 = busy_cnt;
    send(16'h0001);
    ticks(20);
    check("timeout_busy", 32'(busy_cnt - b0), 16);
    check("timeout_fault", 32'(bus.fault), 1);
    check("timeout_resets", 32'({bus.pll0_reset, bus.pll1_reset}), 32'b11);
    bus.pll1_locked = 1; w0 = wave_cnt;
    send(16'h0003);
    check("fault_cleared", 32'(bus.fault), 0);
    wait_idle(200);
    check("recover_wave", 32'(wave_cnt - w0), 32'(FRAME_CYC));
    w0 = wave_cnt; f0 = fd_cnt;
    send(16'h00FF);
    wait_wave(10);
    ticks(5 * SC + 1);
    send(16'h0F00);
    wait_idle(400);
    check("chain_wave", 32'(wave_cnt - w0), 32'(2 * FRAME_CYC));
    check("chain_run", 32'(last_run), 32'(2 * FRAME_CYC));
    check("chain_done", 32'(fd_cnt - f0), 1);
    f0 = fd_cnt;
    send(16'h0001);
    wait_wave(10);
    ticks(SC);
    send(16'h8000);
    ticks(SC);
    send(16'h0000);
    check("abort_wave", 32'(bus.wave_enable), 0);
    w0 = wave_cnt;
    ticks(NSYM * SC + 10);
    check("abort_pending", 32'(wave_cnt - w0), 0);
    check("abort_done", 32'(fd_cnt - f0), 0);
    send(16'h1234);
    wait_wave(10);
    ticks(7 * SC + 1);
    bus.pll0_locked = 0;
    tick();
    check("lockloss", 32'({bus.wave_enable, bus.fault}), 32'b01);
    bus.pll0_locked = 1;
    ticks(2);
    send(16'h00F0);
    wait_wave(10);
    ticks(10);
    check("pre_reset_wave", 32'(bus.wave_enable), 1);
    #2 reset_b = 0;
    #1 check("async_reset_wave", 32'(bus.wave_enable), 0);
    tick();
    reset_b = 1;
    ticks(2);
    lk0 = 0; lk1 = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        bus.frame_valid = ~bus.frame_valid;
        if (bus.frame_valid) bus.frame_data = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      end
      if (lk0 == 0 && $urandom_range(0, 399) == 0) lk0 = $urandom_range(1, 40);
      if (lk1 == 0 && $urandom_range(0, 399) == 0) lk1 = $urandom_range(1, 40);
      bus.pll0_locked = (lk0 == 0);
      bus.pll1_locked = (lk1 == 0);
      if (lk0 > 0) lk0--;
      if (lk1 > 0) lk1--;
      if ($urandom_range(0, 1999) == 0) begin
        reset_b = 0;
        tick();
        reset_b = 1;
      end
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fsk_symbol_scheduler.md
FSK_SYMBOL_SCHEDULER -- requirements
Module: fsk_symbol_scheduler

Interface
REQ-001 SHALL have parameter SYMBOL_CYCLES, default 12000, meaning clock cycles per transmitted symbol (1 kbaud at 12 MHz); legal range 2..65535.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4096, meaning maximum cycles to wait for both PLL locks; legal range 2..65535.
REQ-003 SHALL have ports: clk  input  1  system clock (12 MHz domain).
REQ-004 SHALL have ports: reset_b  input  1  reset.
REQ-005 SHALL have ports: frame_data  input  16  received UART word.
REQ-006 SHALL have ports: frame_valid  input  1  word valid; level signal, may stay high for many cycles.
REQ-007 SHALL have ports: pll0_locked  input  1  lock from the 888 MHz PLL, which carries symbol 0.
REQ-008 SHALL have ports: pll1_locked  input  1  lock from the 936 MHz PLL, which carries symbol 1.
REQ-009 SHALL have ports: pll0_reset and pll1_reset  output  1 each  PLL resets, active high.
REQ-010 SHALL have ports: freq_select  output  1  current symbol; 1 selects the 936 MHz PLL.
REQ-011 SHALL have ports: wave_enable  output  1  gates the antenna drive.
REQ-012 SHALL have ports: busy  output  1  ARM or TX; frame_done  output  1  one-cycle pulse; fault  output  1  sticky lock fault.
REQ-013 SHALL use one clock; reset is asynchronous and active-low (reset_b).

Function
REQ-014 SHALL detect a frame only on a rising edge of frame_valid, using a registered previous value; frame_data is sampled on the edge cycle.
REQ-015 SHALL implement states IDLE, ARM, TX and FAULT. All outputs are registered.
REQ-016 In IDLE/FAULT: pll0_reset=pll1_reset=1, wave_enable=0, busy=0. In ARM/TX: both resets=0, busy=1.
REQ-017 On a non-zero frame edge in IDLE or FAULT, the block loads the shift register, clears fault and enters ARM on the next cycle.
REQ-018 A zero word edge in IDLE is ignored.
REQ-019 In ARM, a counter increments each cycle. When pll0_locked and pll1_locked are both sampled high, the block enters TX on the next cycle.
REQ-020 In ARM, if the counter reaches LOCK_TIMEOUT without both locks, the block enters FAULT and sets fault=1.
REQ-021 In TX, frame bits are sent LSB first. freq_select equals the current bit and wave_enable=1. Each symbol lasts exactly SYMBOL_CYCLES cycles, with no gap cycles between symbols.
REQ-022 After the 16th data symbol, the pending buffer is checked:
- if a word is pending, it is loaded and TX continues with its bit 0 on the following cycle, with no gap and no re-arm;
- otherwise the block returns to IDLE and pulses frame_done for one cycle.
REQ-023 A single-entry pending buffer captures a non-zero frame edge seen during ARM or TX. A newer edge overwrites an older pending word.
REQ-024 A zero-word edge during ARM or TX aborts: the pending buffer is cleared, the block goes to IDLE next cycle, wave_enable drops and frame_done is not pulsed.
REQ-025 If either lock input is low during TX, the block goes to FAULT next cycle with fault=1; the pending buffer is cleared.
REQ-026 If a zero-word edge and a lock loss occur in the same cycle, the zero word takes priority and fault is not set.
REQ-027 If a frame edge coincides with the final symbol boundary, that word is the one loaded by REQ-022.
REQ-028 Symbol and lock counters are 16 bits wide and reset to 0 on every state entry.

Reset
REQ-029 While reset_b=0, all state SHALL clear asynchronously: state=IDLE, pll0_reset=pll1_reset=1, freq_select=0, wave_enable=0, busy=0, frame_done=0, fault=0, pending empty.
REQ-030 A reset asserted mid-frame SHALL force wave_enable=0 immediately, without waiting for a clock edge.
REQ-031 Release of reset_b SHALL be treated as synchronous to clk by the integrator.

Configuration
REQ-032 Macro FSK_PREAMBLE_EN, when defined, SHALL prepend 8 preamble symbols (1,0,1,0,1,0,1,0) to every frame, including chained frames; each preamble symbol lasts SYMBOL_CYCLES cycles.
REQ-033 With FSK_PREAMBLE_EN undefined, TX SHALL start directly with data bit 0, and a frame lasts 16*SYMBOL_CYCLES cycles.

Verification
REQ-034 With SYMBOL_CYCLES=4 and both locks high, send word 0x0005. Required: freq_select = 1,0,1,0,0,...,0, each symbol 4 cycles; wave_enable high for 64 cycles; one frame_done pulse; then IDLE.
REQ-035 With LOCK_TIMEOUT=16 and pll1_locked held 0, send 0x0001. Required: FAULT after 16 ARM cycles, fault=1, both resets=1. A later 0x0003 with locks high clears fault and transmits.
REQ-036 Send 0x00FF, then 0x0F00 at symbol 5. Required: 32 contiguous data symbols with no gap, and a single frame_done.
REQ-037 Send 0x0001, then 0x0000 at symbol 3. Required: wave_enable low one cycle later, no frame_done, pending cleared.
REQ-038 Drop pll0_locked during symbol 7. Required: FAULT, wave_enable=0 and fault=1 next cycle. Also assert reset_b low mid-TX: wave_enable=0 asynchronously.
REQ-039 With FSK_PREAMBLE_EN defined and SYMBOL_CYCLES=4, send 0x0001. Required: 8 alternating preamble symbols, then data; wave_enable high for 96 cycles.
